apb_multi_bridge: RTL and testbench

Parametrised APB master bridge with an N-slave interconnect, the next generation of the two-slave (GPIO/UART) APB bridge. Accepts single read/write requests from the test/host side, drives the APB SETUP/ACCESS sequence, and decodes the address onto one of `NSLV` PSEL lines. Muxes the selected slave's PREADY/PRDATA/PSLVERR back. Adds a wait-state timeout watchdog and per-transfer error reporting.

---
 rtl/apb_pkg.sv | 20 ++
 rtl/apb_slave_mux.sv | 47 ++++
 rtl/apb_multi_bridge.sv | 174 +++++++++++++++++
 tb/tb_apb_multi_bridge.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared definitions for the APB multi-slave bridge: FSM state encoding
// and the error-cause codes reported on Error_Identify.
package apb_pkg;

  // Bridge FSM states; the encoding is visible to anyone probing state_q.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // Cause of the most recent completion.
  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_DECODE  = 3'd1,
    ERR_TIMEOUT = 3'd2,
    ERR_SLVERR  = 3'd3
  } err_t;

endpackage

// File: rtl/apb_slave_mux.sv
// Address decode and response mux for the APB interconnect. The slave index
// is the top SELW bits of the address; indices at or beyond NSLV are a decode
// error and select nobody. Responses from unselected slaves never reach the
// bridge.
module apb_slave_mux #(
  parameter int NSLV = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic                 active_i,
  input  logic [AW-1:0]        paddr_i,
  input  logic [NSLV-1:0]      pready_s_i,
  input  logic [NSLV*DW-1:0]   prdata_s_i,
  input  logic [NSLV-1:0]      pslverr_s_i,
  output logic [NSLV-1:0]      psel_o,
  output logic                 dec_err_o,
  output logic                 pready_o,
  output logic [DW-1:0]        prdata_o,
  output logic                 pslverr_o
);

  localparam int SELW = $clog2(NSLV);

  logic [SELW-1:0] idx;

  assign idx       = paddr_i[AW-1 -: SELW];
  assign dec_err_o = (int'(idx) >= NSLV);

  // One-hot select and response steering for the addressed slave only.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    psel_o    = '0;
    pready_o  = 1'b0;
    prdata_o  = '0;
    pslverr_o = 1'b0;
    for (int i = 0; i < NSLV; i++) begin
      if (active_i && (int'(idx) == i)) begin
        psel_o[i] = 1'b1;
        pready_o  = pready_s_i[i];
        prdata_o  = prdata_s_i[i*DW +: DW];
        pslverr_o = pslverr_s_i[i];
      end
    end
  end

endmodule

// File: rtl/apb_multi_bridge.sv
// APB master bridge driving NSLV slaves. Takes single read/write requests,
// runs SETUP/ACCESS, and reports completion with a one-cycle done pulse plus
// a held error cause (decode, wait-state timeout, or slave error).
module apb_multi_bridge #(
  parameter int NSLV    = 3,
  parameter int AW      = 5,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                 pclk,
  input  logic                 Reset,
  input  logic                 transfer,
  input  logic                 pwrite,
  input  logic [AW-1:0]        addr,
  input  logic [DW-1:0]        write_data,
  output logic [DW-1:0]        read_data,
  output logic                 done,
  output logic                 PSLVERR,
  output logic [2:0]           Error_Identify,
  output logic [NSLV-1:0]      psel,
  output logic                 penable,
  output logic                 pwrite_slave,
  output logic [AW-1:0]        paddr,
  output logic [DW-1:0]        pwdata,
  input  logic [NSLV-1:0]      pready_s,
  input  logic [NSLV*DW-1:0]   prdata_s,
  input  logic [NSLV-1:0]      pslverr_s
);

  import apb_pkg::*;

  // Counter wide enough to reach TIMEOUT; a 1-bit stub when disabled.
  localparam int CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  state_t          state_q;
  logic [AW-1:0]   paddr_q;
  logic [DW-1:0]   pwdata_q;
  logic            pwrite_q;
  logic            penable_q;
  logic            done_q;
  logic            pslverr_q;
  err_t            err_q;
  logic [DW-1:0]   rdata_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;

  logic            sel_ready;
  logic            sel_err;
  logic [DW-1:0]   sel_rdata;
  logic            dec_err;
  logic            in_access;
  logic            timeout_hit;
  logic            complete;
  err_t            err_code;

  assign in_access = (state_q == ACCESS);

  apb_slave_mux #(
    .NSLV (NSLV),
    .AW   (AW),
    .DW   (DW)
  ) u_mux (
    .active_i    (state_q != IDLE),
    .paddr_i     (paddr_q),
    .pready_s_i  (pready_s),
    .prdata_s_i  (prdata_s),
    .pslverr_s_i (pslverr_s),
    .psel_o      (psel),
    .dec_err_o   (dec_err),
    .pready_o    (sel_ready),
    .prdata_o    (sel_rdata),
    .pslverr_o   (sel_err)
  );

  // The watchdog fires on the ACCESS cycle whose un-ready edge would bring
  // the count up to TIMEOUT; a PREADY on that same cycle still wins.
  assign timeout_hit = (TIMEOUT != 0) && in_access && !sel_ready &&
                       (cnt_q == CW'(TO_LAST));
  assign complete    = in_access && (dec_err || sel_ready || timeout_hit);

  // Completion cause, decode first, then slave error, then timeout.
  always_comb begin
    err_code = ERR_NONE;
    if (dec_err)
      err_code = ERR_DECODE;
    else if (sel_ready && sel_err)
      err_code = ERR_SLVERR;
    else if (timeout_hit)
      err_code = ERR_TIMEOUT;
  end

  // Wait-state count: cleared in SETUP, advanced on each un-ready ACCESS cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == SETUP)
      cnt_d = '0;
    else if (in_access && !sel_ready && (TIMEOUT != 0))
      cnt_d = cnt_q + CW'(1);
  end

  // Timeout counter register.
  always_ff @(posedge pclk or posedge Reset) begin
    if (Reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  // Bridge FSM with its registered APB and completion outputs.
  always_ff @(posedge pclk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      penable_q <= 1'b0;
      done_q    <= 1'b0;
      pslverr_q <= 1'b0;
      err_q     <= ERR_NONE;
      rdata_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values, independent of statement order in this block.
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (transfer) begin
            state_q  <= SETUP;
            paddr_q  <= addr;
            pwdata_q <= write_data;
            pwrite_q <= pwrite;
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
        end
        ACCESS: begin
          if (complete) begin
            penable_q <= 1'b0;
            done_q    <= 1'b1;
            err_q     <= err_code;
            pslverr_q <= (err_code != ERR_NONE);
            if (!pwrite_q && (err_code == ERR_NONE))
              rdata_q <= sel_rdata;
            if (transfer) begin
              state_q  <= SETUP;
              paddr_q  <= addr;
              pwdata_q <= write_data;
              pwrite_q <= pwrite;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          penable_q <= 1'b0;
        end
      endcase
    end
  end

  assign read_data      = rdata_q;
  assign done           = done_q;
  assign PSLVERR        = pslverr_q;
  assign Error_Identify = err_q;
  assign penable        = penable_q;
  assign pwrite_slave   = pwrite_q;
  assign paddr          = paddr_q;
  assign pwdata         = pwdata_q;

endmodule

// File: tb/tb_apb_multi_bridge.sv
// Randomised bench for apb_multi_bridge (NSLV=3, AW=5, DW=32, TIMEOUT=4).
// Expected behaviour comes from a transaction-level model: each request's
// completion cycle, error cause and read-data effect are computed from its
// address, wait-state count and slave-error flag.
module tb_apb_multi_bridge;

  localparam int NSLV = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int TO   = 4;

  typedef struct {
    logic        wr;
    logic [4:0]  a;
    logic [31:0] d;
    int          w;    // wait states before PREADY; >= TO means never ready
    logic        se;   // slave flags PSLVERR on its ready cycle
    logic [31:0] sd;   // data the slave returns on its ready cycle
  } req_t;

  logic                 pclk = 1'b0;
  logic                 Reset = 1'b1;
  logic                 transfer = 1'b0;
  logic                 pwrite = 1'b0;
  logic [AW-1:0]        addr = '0;
  logic [DW-1:0]        write_data = '0;
  logic [DW-1:0]        read_data;
  logic                 done;
  logic                 PSLVERR;
  logic [2:0]           Error_Identify;
  logic [NSLV-1:0]      psel;
  logic                 penable;
  logic                 pwrite_slave;
  logic [AW-1:0]        paddr;
  logic [DW-1:0]        pwdata;
  logic [NSLV-1:0]      pready_s = '0;
  logic [NSLV*DW-1:0]   prdata_s = '0;
  logic [NSLV-1:0]      pslverr_s = '0;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] rd_model = '0;

  apb_multi_bridge #(
    .NSLV    (NSLV),
    .AW      (AW),
    .DW      (DW),
    .TIMEOUT (TO)
  ) dut (
    .pclk           (pclk),
    .Reset          (Reset),
    .transfer       (transfer),
    .pwrite         (pwrite),
    .addr           (addr),
    .write_data     (write_data),
    .read_data      (read_data),
    .done           (done),
    .PSLVERR        (PSLVERR),
    .Error_Identify (Error_Identify),
    .psel           (psel),
    .penable        (penable),
    .pwrite_slave   (pwrite_slave),
    .paddr          (paddr),
    .pwdata         (pwdata),
    .pready_s       (pready_s),
    .prdata_s       (prdata_s),
    .pslverr_s      (pslverr_s)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---- reference model ----
  function automatic bit is_dec(input logic [4:0] a);
    return (a[4:3] == 2'd3);
  endfunction

  function automatic logic [2:0] exp_psel(input logic [4:0] a);
    if (is_dec(a)) return 3'b000;
    return 3'(1 << a[4:3]);
  endfunction

  // Number of clock edges from the request edge to the completing edge.
  function automatic int exp_lat(input req_t r);
    if (is_dec(r.a)) return 2;
    if (r.w >= TO)   return 1 + TO;
    return 2 + r.w;
  endfunction

  function automatic logic [2:0] exp_err(input req_t r);
    if (is_dec(r.a)) return 3'd1;
    if (r.w >= TO)   return 3'd2;
    if (r.se)        return 3'd3;
    return 3'd0;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.wr = 1'($urandom);
    r.a  = 5'($urandom);
    r.d  = $urandom;
    r.w  = $urandom_range(0, 5);
    r.se = ($urandom_range(0, 3) == 0);
    r.sd = $urandom;
    return r;
  endfunction

  function automatic req_t mk(input logic wr, input logic [4:0] a, input logic [31:0] d,
                              input int w, input logic se, input logic [31:0] sd);
    req_t r;
    r.wr = wr; r.a = a; r.d = d; r.w = w; r.se = se; r.sd = sd;
    return r;
  endfunction

  // Random traffic on every slave, optionally overriding the addressed one.
  task automatic drive_slaves(input int sel, input logic rdy, input logic se,
                              input logic [31:0] sd, input bit own);
    pready_s  = 3'($urandom);
    pslverr_s = 3'($urandom);
    for (int i = 0; i < NSLV; i++) prdata_s[i*DW +: DW] = $urandom;
    if (own) begin
      pready_s[sel]  = rdy;
      pslverr_s[sel] = rdy ? se : 1'b0;
      if (rdy) prdata_s[sel*DW +: DW] = sd;
    end
  endtask

  task automatic put_req(input logic t, input req_t r);
    transfer   = t;
    pwrite     = r.wr;
    addr       = r.a;
    write_data = r.d;
  endtask

  // Called at a negedge: present the request, return at the negedge after E0.
  task automatic start(input req_t r);
    put_req(1'b1, r);
    drive_slaves(0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge pclk);
  endtask

  // Runs one transfer from the negedge after its request edge (k=0) up to the
  // negedge after its completing edge (k=lat). With chain set, the next
  // request is offered on the completing cycle.
  task automatic xfer(input req_t r, input bit prev_done, input bit chain, input req_t nx);
    int         lat;
    logic [2:0] err;
    bit         dec;
    int         sel;
    req_t       junk;
    lat = exp_lat(r);
    err = exp_err(r);
    dec = is_dec(r.a);
    sel = int'(r.a[4:3]);
    for (int k = 0; k <= lat; k++) begin
      if (k < lat) begin
        check("done_busy", 64'(done), 64'((k == 0) && prev_done));
        check("psel", 64'(psel), 64'(exp_psel(r.a)));
        check("penable", 64'(penable), 64'(k >= 1));
        check("paddr", 64'(paddr), 64'(r.a));
        check("pwdata", 64'(pwdata), 64'(r.d));
        check("pwrite_slave", 64'(pwrite_slave), 64'(r.wr));
        junk = rand_req();
        if (k == lat - 1)
          put_req(chain, chain ? nx : junk);
        else
          put_req(1'($urandom), junk);
        drive_slaves(sel, !dec && (r.w < TO) && (k == r.w + 1), r.se, r.sd, !dec && (k >= 1));
        @(negedge pclk);
      end else begin
        if (!r.wr && (err == 3'd0)) rd_model = r.sd;
        check("done_pulse", 64'(done), 64'(1));
        check("err_id", 64'(Error_Identify), 64'(err));
        check("PSLVERR", 64'(PSLVERR), 64'(err != 3'd0));
        check("read_data", 64'(read_data), 64'(rd_model));
        if (!chain) begin
          check("psel_end", 64'(psel), 64'(0));
          check("penable_end", 64'(penable), 64'(0));
        end
      end
    end
  endtask

  // One idle cycle after a standalone transfer: the done pulse must be gone.
  task automatic idle_check();
    @(negedge pclk);
    check("done_idle", 64'(done), 64'(0));
    check("psel_idle", 64'(psel), 64'(0));
    check("penable_idle", 64'(penable), 64'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_psel"}, 64'(psel), 64'(0));
    check({tag, "_penable"}, 64'(penable), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_pslverr"}, 64'(PSLVERR), 64'(0));
    check({tag, "_errid"}, 64'(Error_Identify), 64'(0));
    check({tag, "_rdata"}, 64'(read_data), 64'(0));
    check({tag, "_paddr"}, 64'(paddr), 64'(0));
    check({tag, "_pwdata"}, 64'(pwdata), 64'(0));
    check({tag, "_pwrite"}, 64'(pwrite_slave), 64'(0));
  endtask

  initial begin
    req_t cur, nxt, r1, r2;
    bit   chain, prev;

    // Reset state.
    repeat (2) @(negedge pclk);
    check_all_zero("rst");
    Reset = 1'b0;
    @(negedge pclk);

    // Zero-wait write to slave 1.
    cur = mk(1'b1, 5'h09, 32'hA5A5_0001, 0, 1'b0, 32'h0);
    start(cur); xfer(cur, 1'b0, 1'b0, cur); idle_check();

    // Read from slave 2 with two wait states.
    cur = mk(1'b0, 5'h12, 32'h0, 2, 1'b0, 32'hDEAD_BEEF);
    start(cur); xfer(cur, 1'b0, 1'b0, cur); idle_check();

    // Decode error on index 3; read_data keeps DEADBEEF.
    cur = mk(1'b0, 5'h1C, 32'h0, 0, 1'b0, 32'h1234_5678);
    start(cur); xfer(cur, 1'b0, 1'b0, cur); idle_check();

    // Slave 0 never ready: watchdog abort.
    cur = mk(1'b0, 5'h02, 32'h0, 9, 1'b0, 32'h0BAD_0BAD);
    start(cur); xfer(cur, 1'b0, 1'b0, cur); idle_check();

    // Slave error followed back-to-back by a clean read.
    r1 = mk(1'b1, 5'h09, 32'h1111_2222, 0, 1'b1, 32'h0);
    r2 = mk(1'b0, 5'h0A, 32'h0, 1, 1'b0, 32'hC0DE_0042);
    start(r1); xfer(r1, 1'b0, 1'b1, r2); xfer(r2, 1'b1, 1'b0, r2); idle_check();

    // Just-in-time PREADY on the last cycle before the watchdog.
    cur = mk(1'b0, 5'h11, 32'h0, TO - 1, 1'b0, 32'h5EED_F00D);
    start(cur); xfer(cur, 1'b0, 1'b0, cur); idle_check();

    // Reset during the ACCESS wait of a read.
    cur = mk(1'b0, 5'h12, 32'h0, 3, 1'b0, 32'hFFFF_0000);
    start(cur);
    transfer = 1'b0;
    drive_slaves(2, 1'b0, 1'b0, 32'h0, 1'b1);
    repeat (2) @(negedge pclk);
    Reset = 1'b1;
    #1;
    rd_model = '0;
    check_all_zero("midrst");
    @(negedge pclk);
    check("midrst_done_hold", 64'(done), 64'(0));
    Reset = 1'b0;
    @(negedge pclk);
    check("midrst_done_after", 64'(done), 64'(0));
    cur = mk(1'b0, 5'h12, 32'h0, 0, 1'b0, 32'h7777_8888);
    start(cur); xfer(cur, 1'b0, 1'b0, cur); idle_check();

    // Random traffic with random back-to-back chaining.
    cur  = rand_req();
    prev = 1'b0;
    start(cur);
    for (int i = 0; i < 60; i++) begin
      nxt   = rand_req();
      chain = (i < 59) && ($urandom_range(0, 1) == 1);
      xfer(cur, prev, chain, nxt);
      if (!chain) begin
        idle_check();
        if (i < 59) start(nxt);
      end
      prev = chain;
      cur  = nxt;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Safety net against a stuck simulation.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
